eth_recv_stream: RTL and testbench
==================================

ETH_RECV_STREAM -- requirements
Module: eth_recv_stream

Interface
REQ-001 Parameter DEST_MAC_ADDR, 48'h00_0a_95_9d_68_16, station address, byte k = bits [8k+7:8k], k=0 received first.
REQ-002 Parameter PREAMBLE_LEN, 7, number of 8'hAA bytes before SFD (1..15).
REQ-003 Parameter FCS_BYTES, 4, number of check bytes after payload (1..8).
REQ-004 Parameter MAX_PAYLOAD, 1500, largest accepted length field value.
REQ-005 Parameter FIFO_DEPTH, 16, payload output buffer entries (power of two, >=2).
REQ-006 Parameter ACCEPT_BCAST, 1, when 1 also accept destination 48'hFF_FF_FF_FF_FF_FF.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 start  in  1  frame-start pulse, honoured only in IDLE.
REQ-010 in_data  in  8  received byte.
REQ-011 in_vld  in  1  in_data valid this cycle; no input backpressure.
REQ-012 out_data  out  8  payload byte at FIFO head.
REQ-013 out_vld  out  1  FIFO non-empty.
REQ-014 out_rdy  in  1  consumer accepts out_data when out_vld&out_rdy.
REQ-015 out_last  out  1  head byte is final payload byte of its frame.
REQ-016 stat_vld  out  1  one-cycle frame-end status pulse.
REQ-017 stat_code  out  3  0 OK, 1 BAD_PREAMBLE, 2 BAD_SFD, 3 ADDR_MISMATCH, 4 TOO_LONG, 5 BAD_FCS, 6 OVERFLOW.
REQ-018 ready  out  1  high exactly when FSM is IDLE.

Function
REQ-019 FSM states IDLE, PREAMBLE, SFD, MACDST, MACSRC, PLLEN, PL, FCS; every non-IDLE state advances only on in_vld beats, holding state and counter when in_vld=0.
REQ-020 IDLE->PREAMBLE on start; the start cycle's in_data is not consumed.
REQ-021 PREAMBLE: each beat must be 8'hAA else BAD_PREAMBLE; after PREAMBLE_LEN beats ->SFD.
REQ-022 SFD: beat must be 8'hAB else BAD_SFD; ->MACDST.
REQ-023 MACDST: 6 beats; frame accepted when all match DEST_MAC_ADDR bytes in order, or all 8'hFF with ACCEPT_BCAST=1; otherwise ADDR_MISMATCH reported after the sixth beat.
REQ-024 MACSRC: 6 beats, ignored except for checksum; ->PLLEN.
REQ-025 PLLEN: 2 beats, first is MSB; value >MAX_PAYLOAD gives TOO_LONG; value 0 ->FCS directly, else ->PL.
REQ-026 PL: length beats, each written to FIFO; last one tagged out_last; write attempted while FIFO full gives OVERFLOW, byte dropped.
REQ-027 Checksum: 8-bit modulo-256 sum of all MACDST, MACSRC, PLLEN and PL bytes, reset at start.
REQ-028 FCS: each of FCS_BYTES beats must equal two's complement of checksum, else BAD_FCS; after last beat report OK.
REQ-029 Every error terminates the frame on the offending beat; FSM ->IDLE on the next edge.
REQ-030 stat_vld pulses for one cycle, the cycle after the terminating beat, with stat_code registered; FSM is IDLE that same cycle.
REQ-031 Payload latency: byte written on edge N is visible with out_vld=1 in cycle N+1 if FIFO was empty.
REQ-032 FIFO read and write in the same cycle allowed, including when full (read frees slot first: no OVERFLOW).
REQ-033 Bytes already in FIFO from an erroneous frame stay and drain normally; consumer uses stat_code to discard.
REQ-034 start outside IDLE is ignored.

Reset
REQ-035 rst_n low asynchronously forces IDLE, counters 0, checksum 0, FIFO empty, out_vld=0, out_last=0, out_data=0, stat_vld=0, stat_code=0, ready=1.
REQ-036 Reset mid-frame discards the frame without a stat_vld pulse.

Structure
REQ-037 Package eth_recv_pkg holds state_t, stat_code_t enum, PREAMBLE_BYTE 8'hAA, SFD_BYTE 8'hAB, BCAST_ADDR.
REQ-038 FIFO is sub-module eth_recv_fifo (9-bit entries: data plus last), parameter DEPTH.

Verification
REQ-039 Defaults, 7xAA, AB, 16 68 9d 95 0a 00, six 00, 00 02, 01 02, four 41 -> out 01, 02(last); stat OK.
REQ-040 Same frame, fourth FCS byte 42 -> payload 01,02 delivered; stat BAD_FCS after that beat.
REQ-041 Destination all FF, ACCEPT_BCAST=1 -> accepted; ACCEPT_BCAST=0 -> ADDR_MISMATCH, no FIFO writes.
REQ-042 Third preamble byte 8'h55 -> BAD_PREAMBLE one cycle later, ready=1.
REQ-043 FIFO_DEPTH=4, out_rdy=0, length 6 -> four bytes buffered, OVERFLOW on fifth payload beat.
REQ-044 in_vld toggled randomly plus rst_n low mid-payload -> identical results when stalled; after reset FIFO empty, no stat pulse.

Source files
------------

// File: rtl/eth_recv_pkg.sv
// Shared types and constants for the Ethernet-style receive stream block.
package eth_recv_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_MACDST, S_MACSRC, S_PLLEN, S_PL, S_FCS
  } state_t;

  typedef enum logic [2:0] {
    ST_OK            = 3'd0,
    ST_BAD_PREAMBLE  = 3'd1,
    ST_BAD_SFD       = 3'd2,
    ST_ADDR_MISMATCH = 3'd3,
    ST_TOO_LONG      = 3'd4,
    ST_BAD_FCS       = 3'd5,
    ST_OVERFLOW      = 3'd6
  } stat_code_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0]  SFD_BYTE      = 8'hAB;
  localparam logic [47:0] BCAST_ADDR    = 48'hFF_FF_FF_FF_FF_FF;

  // Byte k of a MAC address; byte 0 is the first one on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] k);
    logic [47:0] sh;
    sh = addr >> {k, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/eth_recv_fifo.sv
// Payload buffer: {last, data} entries, extra pointer bit separates full from empty.
module eth_recv_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = rd_i && !empty_o;
  // A read in the same cycle frees the slot the write lands in.
  assign wr_en   = wr_i && (!full_o || rd_en);

  // Head is forced to zero while empty so the output is clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Storage array, no reset needed since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/eth_recv_stream.sv
// Frame receiver: parses preamble/SFD/addresses/length, streams payload
// into a FIFO and reports a one-cycle status code at frame end.
module eth_recv_stream import eth_recv_pkg::*; #(
  parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
  parameter int          PREAMBLE_LEN  = 7,
  parameter int          FCS_BYTES     = 4,
  parameter int          MAX_PAYLOAD   = 1500,
  parameter int          FIFO_DEPTH    = 16,
  parameter bit          ACCEPT_BCAST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_vld,
  output logic [7:0] out_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       stat_vld,
  output logic [2:0] stat_code,
  output logic       ready
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] FCS_LAST = 16'(FCS_BYTES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  state_t     state_q;
  logic [15:0] cnt_q, len_q;
  logic [7:0]  csum_q, len_hi_q;
  logic        uc_ok_q, bc_ok_q;
  logic        stat_vld_q;
  stat_code_t  stat_code_q;

  logic [7:0]  csum_d, fcs_exp;
  logic [15:0] len_d;
  logic        uc_ok_d, bc_ok_d, pl_last;
  logic        fifo_wr, fifo_rd, fifo_ok, fifo_full, fifo_empty;
  logic [8:0]  fifo_head;

  // Per-beat helpers: running sum, assembled length, address match tracking.
  always_comb begin
    csum_d  = csum_q + in_data;
    fcs_exp = ~csum_q + 8'd1;
    len_d   = {len_hi_q, in_data};
    uc_ok_d = uc_ok_q && (in_data == mac_byte(DEST_MAC_ADDR, cnt_q[2:0]));
    bc_ok_d = bc_ok_q && (in_data == mac_byte(BCAST_ADDR, cnt_q[2:0]));
    pl_last = (cnt_q == len_q - 16'd1);
  end

  assign fifo_rd = out_vld && out_rdy;
  assign fifo_ok = !fifo_full || fifo_rd;
  assign fifo_wr = (state_q == S_PL) && in_vld && fifo_ok;

  // Frame parser; every error jumps straight back to IDLE with a status pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      len_hi_q    <= '0;
      csum_q      <= '0;
      uc_ok_q     <= 1'b0;
      bc_ok_q     <= 1'b0;
      stat_vld_q  <= 1'b0;
      stat_code_q <= ST_OK;
    end else begin
      stat_vld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_PREAMBLE;
          cnt_q   <= '0;
          csum_q  <= '0;
          uc_ok_q <= 1'b1;
          bc_ok_q <= ACCEPT_BCAST;
        end
        S_PREAMBLE: if (in_vld) begin
          if (in_data != PREAMBLE_BYTE) begin
            state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_BAD_PREAMBLE;
          end else if (cnt_q == PRE_LAST) begin
            state_q <= S_SFD; cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SFD: if (in_vld) begin
          if (in_data != SFD_BYTE) begin
            state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_BAD_SFD;
          end else begin
            state_q <= S_MACDST; cnt_q <= '0;
          end
        end
        S_MACDST: if (in_vld) begin
          csum_q  <= csum_d;
          uc_ok_q <= uc_ok_d;
          bc_ok_q <= bc_ok_d;
          if (cnt_q == 16'd5) begin
            cnt_q <= '0;
            if (uc_ok_d || bc_ok_d) state_q <= S_MACSRC;
            else begin
              state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_ADDR_MISMATCH;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_MACSRC: if (in_vld) begin
          csum_q <= csum_d;
          if (cnt_q == 16'd5) begin
            state_q <= S_PLLEN; cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_PLLEN: if (in_vld) begin
          csum_q <= csum_d;
          if (cnt_q == 16'd0) begin
            len_hi_q <= in_data;
            cnt_q    <= 16'd1;
          end else begin
            len_q <= len_d;
            cnt_q <= '0;
            if (len_d > MAX_LEN) begin
              state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_TOO_LONG;
            end else if (len_d == 16'd0) begin
              state_q <= S_FCS;
            end else begin
              state_q <= S_PL;
            end
          end
        end
        S_PL: if (in_vld) begin
          if (!fifo_ok) begin
            state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_OVERFLOW;
          end else begin
            csum_q <= csum_d;
            if (pl_last) begin
              state_q <= S_FCS; cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        S_FCS: if (in_vld) begin
          if (in_data != fcs_exp) begin
            state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_BAD_FCS;
          end else if (cnt_q == FCS_LAST) begin
            state_q <= S_IDLE; stat_vld_q <= 1'b1; stat_code_q <= ST_OK;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  eth_recv_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_i      (fifo_wr),
    .wr_data_i ({pl_last, in_data}),
    .rd_i      (fifo_rd),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign out_vld   = !fifo_empty;
  assign out_data  = fifo_head[7:0];
  assign out_last  = fifo_head[8];
  assign stat_vld  = stat_vld_q;
  assign stat_code = stat_code_q;
  assign ready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_eth_recv_stream.sv
// Scoreboard bench: dut0 uses defaults, dut1 has ACCEPT_BCAST=0, FIFO_DEPTH=4.
module tb_eth_recv_stream;

  typedef logic [8:0] ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_vld = 1'b0;
  logic       out_rdy = 1'b1;

  logic [7:0] o_data0, o_data1;
  logic       o_vld0, o_vld1, o_last0, o_last1, st_vld0, st_vld1, rdy0, rdy1;
  logic [2:0] st_code0, st_code1;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] frm[$];
  ent_t exp_pl0[$], exp_pl1[$];
  int   exp_st0[$], exp_st1[$];
  int   term[2];
  ent_t e0, e1;
  int   s0, s1;

  always #5 clk = ~clk;

  eth_recv_stream u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_vld(in_vld),
    .out_data(o_data0), .out_vld(o_vld0), .out_rdy(out_rdy), .out_last(o_last0),
    .stat_vld(st_vld0), .stat_code(st_code0), .ready(rdy0)
  );

  eth_recv_stream #(.ACCEPT_BCAST(1'b0), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_vld(in_vld),
    .out_data(o_data1), .out_vld(o_vld1), .out_rdy(out_rdy), .out_last(o_last1),
    .stat_vld(st_vld1), .stat_code(st_code1), .ready(rdy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_vld0 && out_rdy) begin
        if (exp_pl0.size() == 0) chk("pl0_extra", 1, 0);
        else begin e0 = exp_pl0.pop_front(); chk("pl0", {23'b0, o_last0, o_data0}, {23'b0, e0}); end
      end
      if (o_vld1 && out_rdy) begin
        if (exp_pl1.size() == 0) chk("pl1_extra", 1, 0);
        else begin e1 = exp_pl1.pop_front(); chk("pl1", {23'b0, o_last1, o_data1}, {23'b0, e1}); end
      end
      if (st_vld0) begin
        chk("st0_ready", {31'b0, rdy0}, 1);
        if (exp_st0.size() == 0) chk("st0_extra", 1, 0);
        else begin s0 = exp_st0.pop_front(); chk("st0_code", {29'b0, st_code0}, s0); end
      end
      if (st_vld1) begin
        chk("st1_ready", {31'b0, rdy1}, 1);
        if (exp_st1.size() == 0) chk("st1_extra", 1, 0);
        else begin s1 = exp_st1.pop_front(); chk("st1_code", {29'b0, st_code1}, s1); end
      end
    end
  end

  // Build a well-formed frame into frm (default preamble/FCS lengths).
  task automatic build(input logic [47:0] dst, input logic [15:0] len);
    logic [7:0] s;
    s = 8'h00;
    frm.delete();
    repeat (7) frm.push_back(8'hAA);
    frm.push_back(8'hAB);
    for (int k = 0; k < 6; k++) begin frm.push_back(dst[8*k +: 8]); s = s + dst[8*k +: 8]; end
    repeat (6) frm.push_back(8'h00);
    frm.push_back(len[15:8]); frm.push_back(len[7:0]);
    s = s + len[15:8] + len[7:0];
    for (int p = 0; p < int'(len); p++) begin frm.push_back(8'(p + 1)); s = s + 8'(p + 1); end
    repeat (4) frm.push_back(8'h00 - s);
  endtask

  task automatic fin(input int d, input int code, input int idx);
    term[d] = idx;
    if (d == 0) exp_st0.push_back(code); else exp_st1.push_back(code);
  endtask

  // Reference model walking frm; rdy_low means the consumer never reads.
  task automatic predict(input int d, input bit bc_en, input int depth, input bit rdy_low);
    int i; logic [7:0] s; logic uc, bc; logic [15:0] len;
    logic [47:0] me;
    me = 48'h00_0a_95_9d_68_16;
    i = 0; s = 8'h00; uc = 1'b1; bc = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (frm[i] != 8'hAA) begin fin(d, 1, i); return; end
      i++;
    end
    if (frm[i] != 8'hAB) begin fin(d, 2, i); return; end
    i++;
    for (int k = 0; k < 6; k++) begin
      if (frm[i] != me[8*k +: 8]) uc = 1'b0;
      if (frm[i] != 8'hFF) bc = 1'b0;
      s = s + frm[i]; i++;
    end
    if (!(uc || (bc_en && bc))) begin fin(d, 3, i - 1); return; end
    for (int k = 0; k < 6; k++) begin s = s + frm[i]; i++; end
    len = {frm[i], frm[i+1]};
    s = s + frm[i] + frm[i+1];
    i += 2;
    if (len > 16'd1500) begin fin(d, 4, i - 1); return; end
    for (int p = 0; p < int'(len); p++) begin
      if (rdy_low && p >= depth) begin fin(d, 6, i); return; end
      if (d == 0) exp_pl0.push_back({p == int'(len) - 1, frm[i]});
      else        exp_pl1.push_back({p == int'(len) - 1, frm[i]});
      s = s + frm[i]; i++;
    end
    for (int k = 0; k < 4; k++) begin
      if (frm[i] != 8'h00 - s) begin fin(d, 5, i); return; end
      i++;
    end
    fin(d, 0, i - 1);
  endtask

  // Drive frm; optional random stalls, payload-latency check, reset at byte abort_at.
  task automatic send(input bit stall, input bit lat, input int abort_at);
    int n;
    n = frm.size();
    @(posedge clk); #1;
    chk("ready_idle", {31'b0, rdy0}, 1);
    start = 1'b1; in_vld = 1'b1; in_data = 8'h00;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i > 0 && i - 1 == term[0]) chk("st0_latency", {31'b0, st_vld0}, 1);
      if (i > 0 && i - 1 == term[1]) chk("st1_latency", {31'b0, st_vld1}, 1);
      if (lat && i == 23) chk("pl_latency", {31'b0, o_vld0}, 1);
      if (i == abort_at) begin
        rst_n = 1'b0; in_vld = 1'b0;
        @(posedge clk); #1;
        exp_pl0.delete(); exp_pl1.delete(); exp_st0.delete(); exp_st1.delete();
        chk("rst_out_vld", {31'b0, o_vld0}, 0);
        chk("rst_ready", {31'b0, rdy0}, 1);
        chk("rst_stat", {31'b0, st_vld0}, 0);
        rst_n = 1'b1;
        return;
      end
      if (i == n) begin in_vld = 1'b0; break; end
      if (stall) while ($urandom_range(0, 2) == 0) begin
        in_vld = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
      in_vld = 1'b1; in_data = frm[i];
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_pl0.size() + exp_pl1.size() + exp_st0.size() + exp_st1.size()) != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    chk("drain_pl0", exp_pl0.size(), 0);
    chk("drain_pl1", exp_pl1.size(), 0);
    chk("drain_st0", exp_st0.size(), 0);
    chk("drain_st1", exp_st1.size(), 0);
  endtask

  task automatic run(input bit stall, input bit lat, input bit rdy_low);
    predict(0, 1'b1, 16, rdy_low);
    predict(1, 1'b0, 4, rdy_low);
    send(stall, lat, -1);
    out_rdy = 1'b1;
    drain();
  endtask

  initial begin
    #3;
    chk("rst_out_vld", {31'b0, o_vld0}, 0);
    chk("rst_out_last", {31'b0, o_last0}, 0);
    chk("rst_out_data", {24'b0, o_data0}, 0);
    chk("rst_stat_vld", {31'b0, st_vld0}, 0);
    chk("rst_stat_code", {29'b0, st_code0}, 0);
    chk("rst_ready", {31'b0, rdy0}, 1);
    #20 rst_n = 1'b1;

    // Reference frame, then corrupted last FCS byte.
    build(48'h00_0a_95_9d_68_16, 16'd2);
    run(1'b0, 1'b1, 1'b0);
    build(48'h00_0a_95_9d_68_16, 16'd2);
    frm[frm.size() - 1] = 8'h42;
    run(1'b0, 1'b0, 1'b0);
    // Broadcast: accepted by dut0, rejected by dut1.
    build(48'hFF_FF_FF_FF_FF_FF, 16'd3);
    run(1'b0, 1'b0, 1'b0);
    // Bad preamble, bad SFD, foreign unicast address.
    build(48'h00_0a_95_9d_68_16, 16'd2);
    frm[2] = 8'h55;
    run(1'b0, 1'b0, 1'b0);
    build(48'h00_0a_95_9d_68_16, 16'd2);
    frm[7] = 8'h55;
    run(1'b0, 1'b0, 1'b0);
    build(48'h00_0a_95_9d_68_17, 16'd2);
    run(1'b0, 1'b0, 1'b0);
    // Length boundaries: 1501 rejected, 0 and 1500 accepted.
    build(48'h00_0a_95_9d_68_16, 16'd2);
    frm[20] = 8'h05; frm[21] = 8'hDD;
    run(1'b0, 1'b0, 1'b0);
    build(48'h00_0a_95_9d_68_16, 16'd0);
    run(1'b0, 1'b0, 1'b0);
    build(48'h00_0a_95_9d_68_16, 16'd1500);
    run(1'b0, 1'b0, 1'b0);
    // Consumer stalled: dut1 (4 entries) overflows on the fifth payload beat.
    out_rdy = 1'b0;
    build(48'h00_0a_95_9d_68_16, 16'd6);
    run(1'b0, 1'b0, 1'b1);
    // Random input stalls must not change results.
    build(48'h00_0a_95_9d_68_16, 16'd20);
    run(1'b1, 1'b0, 1'b0);
    // Reset mid-payload: frame discarded, FIFO empty, no status pulse.
    build(48'h00_0a_95_9d_68_16, 16'd10);
    predict(0, 1'b1, 16, 1'b0);
    predict(1, 1'b0, 4, 1'b0);
    send(1'b1, 1'b0, 26);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_vld0", {31'b0, o_vld0}, 0);
    chk("post_rst_vld1", {31'b0, o_vld1}, 0);
    chk("post_rst_ready", {31'b0, rdy0}, 1);
    // Receiver still works after the reset.
    build(48'h00_0a_95_9d_68_16, 16'd4);
    run(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
